// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate controller.
package parking_pkg;

  localparam int unsigned DEB_CYCLES_DEF     = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE,
    ENT_A,
    ENT_AB,
    ENT_B,
    EXT_B,
    EXT_BA,
    EXT_A,
    DENY
  } gate_state_t;

  function automatic logic is_passage(input gate_state_t s);
    return (s == ENT_A) || (s == ENT_AB) || (s == ENT_B) ||
           (s == EXT_B) || (s == EXT_BA) || (s == EXT_A);
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser followed by a counting debouncer for one raw beam sensor.
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  logic       sync_1;
  logic       sync_2;
  logic [7:0] cnt;

  // level flips on the DEB_CYCLES-th consecutive cycle that sync_2 disagrees with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == 8'(DEB_CYCLES - 1)) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Two-beam parking gate controller: direction detection, lot-full denial, pulse outputs.
// Define GATE_TIMEOUT_EN to abandon passages that stall for TIMEOUT_CYCLES cycles.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sens_a,
  input  logic sens_b,
  input  logic lot_full,
  output logic entry_pulse,
  output logic exit_pulse,
  output logic gate_open,
  output logic denied
);

  if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_bad_deb
    $error("DEB_CYCLES out of range 2..255");
  end
  if (TIMEOUT_CYCLES < 16 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES out of range 16..65535");
  end

  logic        a_lvl;
  logic        b_lvl;
  logic [1:0]  lv;
  gate_state_t state;
  gate_state_t step;
  gate_state_t nxt;
  logic        tmo_hit;

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk   (clk),
    .reset (reset),
    .raw   (sens_a),
    .level (a_lvl)
  );

  sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk   (clk),
    .reset (reset),
    .raw   (sens_b),
    .level (b_lvl)
  );

  assign lv = {a_lvl, b_lvl};

  always_comb begin
    step = state;
    case (state)
      IDLE: begin
        if (lv == 2'b10)      step = lot_full ? DENY : ENT_A;
        else if (lv == 2'b01) step = EXT_B;
      end
      ENT_A: begin
        if (lv == 2'b11)      step = ENT_AB;
        else if (lv == 2'b00) step = IDLE;
      end
      ENT_AB: begin
        if (lv == 2'b01)      step = ENT_B;
        else if (lv == 2'b00) step = IDLE;
      end
      EXT_B: begin
        if (lv == 2'b11)      step = EXT_BA;
        else if (lv == 2'b00) step = IDLE;
      end
      EXT_BA: begin
        if (lv == 2'b10)      step = EXT_A;
        else if (lv == 2'b00) step = IDLE;
      end
      ENT_B, EXT_A, DENY: begin
        if (lv == 2'b00)      step = IDLE;
      end
      default: step = IDLE;
    endcase
  end

`ifdef GATE_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (state != IDLE) && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            tmo_cnt <= '0;
    else if (nxt != state || state == IDLE) tmo_cnt <= '0;
    else                                  tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // A level-driven move always wins; the timeout only fires on a cycle that would otherwise hold.
  assign nxt = (step == state && tmo_hit) ? IDLE : step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gate_open   <= 1'b0;
      denied      <= 1'b0;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      state       <= nxt;
      gate_open   <= is_passage(state);
      denied      <= (state == DENY);
      entry_pulse <= (state == ENT_B) && (step == IDLE);
      exit_pulse  <= (state == EXT_A) && (step == IDLE);
    end
  end

endmodule
